// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for a combinational ALU: register file, IDLE/EXEC/WB FSM and writeback.
// Optional build macro X0_HARDWIRED_EN makes register 0 read as zero and ignore writes.
module alu_operand_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  use_imm,
  input  logic                  op_sel,
  output logic                  ALUctrl,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [DATA_WIDTH-1:0] ALUout,
  input  logic                  EQ,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq_flag,
  output logic [DATA_WIDTH-1:0] a0
);

  // state | meaning
  // IDLE  | ready for an instruction, fields latched on handshake
  // EXEC  | operands on the ALU bus, result/EQ captured at end of cycle
  // WB    | result written to rd, done pulses
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic                  use_imm_q, op_sel_q;
  logic                  ready_q, done_q, eq_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic                  wr_allowed;

  always_comb begin
    rs1_val = rf_q[rs1_q];
    rs2_val = rf_q[rs2_q];
`ifdef X0_HARDWIRED_EN
    if (rs1_q == '0) rs1_val = '0;
    if (rs2_q == '0) rs2_val = '0;
    wr_allowed = (rd_q != '0);
`else
    wr_allowed = 1'b1;
`endif
  end

  // ALU bus is only live during EXEC so the ALU sees quiet inputs otherwise.
  always_comb begin
    ALUop1  = '0;
    ALUop2  = '0;
    ALUctrl = 1'b0;
    if (state_q == EXEC) begin
      ALUop1  = rs1_val;
      ALUop2  = use_imm_q ? imm_q : rs2_val;
      ALUctrl = op_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      op_sel_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            rd_q      <= rd;
            imm_q     <= imm;
            use_imm_q <= use_imm;
            op_sel_q  <= op_sel;
            ready_q   <= 1'b0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          result_q <= ALUout;
          eq_q     <= EQ;
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          if (wr_allowed) rf_q[rd_q] <= result_q;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign result      = result_q;
  assign eq_flag     = eq_q;
  assign a0          = rf_q[A0_IDX];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with an in-bench add/sub ALU and register-file model.
module tb_alu_operand_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [DW-1:0] imm = '0;
  logic          use_imm = 1'b0, op_sel = 1'b0;
  logic          ALUctrl;
  logic [DW-1:0] ALUop1, ALUop2, ALUout;
  logic          EQ;
  logic          done;
  logic [DW-1:0] result;
  logic          eq_flag;
  logic [DW-1:0] a0;

  alu_operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .op_sel(op_sel),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUout(ALUout), .EQ(EQ),
    .done(done), .result(result), .eq_flag(eq_flag), .a0(a0)
  );

  always #5 clk = ~clk;

  // ALU: op_sel 0 adds, 1 subtracts.
  assign ALUout = ALUctrl ? (ALUop1 - ALUop2) : (ALUop1 + ALUop2);
  assign EQ     = (ALUop1 == ALUop2);

  typedef struct {
    logic [DW-1:0] res;
    logic          eq;
    logic [AW-1:0] rd;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mdl [32];
  logic [DW-1:0] shadow_a0 = '0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_acc = -100;
  logic [DW-1:0] last_op1 = '0, last_op2 = '0;
  logic          last_ctl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
`ifdef X0_HARDWIRED_EN
    if (a == '0) return '0;
`endif
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    sbq.delete();
    shadow_a0 = '0;
    last_acc  = -100;
  endtask

  // Called at a negedge: drive, check ready/ALU bus, record accept, advance to next negedge.
  task automatic cycle(input bit v, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] d, input logic [DW-1:0] im, input bit ui,
                       input bit op, output bit acc);
    logic [DW-1:0] o1, o2, r;
    bit exp_rdy;
    acc = 1'b0;
    instr_valid = v; rs1 = a1; rs2 = a2; rd = d; imm = im; use_imm = ui; op_sel = op;
    exp_rdy = (cyc >= last_acc + 3);
    chk(instr_ready === exp_rdy, "instr_ready", 64'(instr_ready), 64'(exp_rdy));
    if (cyc == last_acc + 1) begin
      chk(ALUop1 === last_op1, "ALUop1_exec", 64'(ALUop1), 64'(last_op1));
      chk(ALUop2 === last_op2, "ALUop2_exec", 64'(ALUop2), 64'(last_op2));
      chk(ALUctrl === last_ctl, "ALUctrl_exec", 64'(ALUctrl), 64'(last_ctl));
    end else begin
      chk(ALUop1 === '0 && ALUop2 === '0 && ALUctrl === 1'b0, "alu_bus_quiet",
          64'(ALUop1 | ALUop2), 64'(0));
    end
    if (v && instr_ready) begin
      o1 = mread(a1);
      o2 = ui ? im : mread(a2);
      r  = op ? (o1 - o2) : (o1 + o2);
      sbq.push_back('{r, (o1 == o2), d, cyc + 2});
`ifdef X0_HARDWIRED_EN
      if (d != '0) mdl[d] = r;
`else
      mdl[d] = r;
`endif
      last_acc = cyc; last_op1 = o1; last_op2 = o2; last_ctl = op;
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] d,
                       input logic [DW-1:0] im, input bit ui, input bit op);
    bit acc = 1'b0;
    int g = 0;
    while (!acc) begin
      if (g >= 8) begin
        chk(1'b0, "issue_timeout", 64'(g), 64'(0));
        break;
      end
      cycle(1'b1, a1, a2, d, im, ui, op, acc);
      g++;
    end
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit dummy;
    repeat (n) cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, dummy);
  endtask

  // Monitor: a0 tracks completed writebacks; every done pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk(a0 === shadow_a0, "a0", 64'(a0), 64'(shadow_a0));
        if (done) begin
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_done", 64'(1), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk(result === e.res, "result", 64'(result), 64'(e.res));
            chk(eq_flag === e.eq, "eq_flag", 64'(eq_flag), 64'(e.eq));
            chk(cyc == e.cyc, "done_latency", 64'(cyc), 64'(e.cyc));
            if (e.rd == AW'(10)) shadow_a0 = e.res;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n_acc;
    bit acc;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk(done === 1'b0, "rst_done", 64'(done), 64'(0));
    chk(result === '0, "rst_result", 64'(result), 64'(0));
    chk(eq_flag === 1'b0, "rst_eq_flag", 64'(eq_flag), 64'(0));
    chk(a0 === '0, "rst_a0", 64'(a0), 64'(0));
    chk(ALUop1 === '0 && ALUop2 === '0 && ALUctrl === 1'b0, "rst_alu_bus", 64'(ALUop1 | ALUop2), 64'(0));
    rst_n = 1'b1;

    issue(5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b0);
    issue(5'd1, 5'd1, 5'd10, 32'd0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(5'd1, 5'd0, 5'd2, 32'd1, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd4, 32'd0, 1'b1, 1'b0);
    issue(5'd10, 5'd1, 5'd5, 32'd0, 1'b0, 1'b1);

    idle(3);
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            $urandom, 1'($urandom), 1'($urandom), acc);
      n_acc += int'(acc);
    end
    instr_valid = 1'b0;
    chk(n_acc == 4, "hold_valid_accepts", 64'(n_acc), 64'(4));

    idle(3);
    issue(5'd0, 5'd0, 5'd3, 32'd9, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk(done === 1'b0, "rst_mid_exec_done", 64'(done), 64'(0));
    @(negedge clk);
    chk(done === 1'b0, "rst_mid_exec_done2", 64'(done), 64'(0));
    rst_n = 1'b1;
    issue(5'd3, 5'd0, 5'd6, 32'd0, 1'b1, 1'b0);
    issue(5'd0, 5'd3, 5'd7, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      idle($urandom_range(0, 2));
      issue(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom,
            1'($urandom), 1'($urandom));
    end

    idle(6);
    chk(sbq.size() == 0, "scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
